// File: rtl/mem_access_if.sv
// Request/response and memory-port bundle for mem_access_unit.
// slave = the access unit, master = CPU datapath plus memory model.
interface mem_access_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 16
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic              req_byte;
   logic              req_byte_hi;
   logic [15:0]       req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  req_valid, req_write, req_byte, req_byte_hi, req_addr, req_wdata,
      input  rsp_ready, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_we
   );

   modport master (
      output req_valid, req_write, req_byte, req_byte_hi, req_addr, req_wdata,
      output rsp_ready, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_we
   );
endinterface

// File: rtl/mem_access_unit.sv
// Initiator for the 32x16 data memory: one load/store per valid/ready handshake, held response.
// Define MEM_BYTE_STORE_EN to enable read-modify-write byte-lane stores.
module mem_access_unit #(
   parameter int ADDR_W    = 5,
   parameter int MEM_DEPTH = 32,
   parameter int DATA_W    = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   mem_access_if.slave     bus
);
   localparam int LANE_W = 8;

`ifdef MEM_BYTE_STORE_EN
   typedef enum logic [2:0] {IDLE, READ, RMW_RD, WRITE, RESP} state_t;
`else
   typedef enum logic [2:0] {IDLE, READ, WRITE, RESP} state_t;
`endif

   state_t            state_q, state_d;
   logic              ready_q;
   logic              err_q;
   logic [DATA_W-1:0] rdata_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              accept;
   logic              out_of_range;

`ifdef MEM_BYTE_STORE_EN
   logic              byte_hi_q;
`else
   logic              unused_byte;
   assign unused_byte = bus.req_byte ^ bus.req_byte_hi;
`endif

   assign accept       = (state_q == IDLE) && ready_q && bus.req_valid;
   assign out_of_range = bus.req_addr >= 16'(MEM_DEPTH);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (out_of_range)       state_d = RESP;
               else if (!bus.req_write) state_d = READ;
`ifdef MEM_BYTE_STORE_EN
               else if (bus.req_byte)   state_d = RMW_RD;
`endif
               else                     state_d = WRITE;
            end
         end
         READ:   state_d = RESP;
`ifdef MEM_BYTE_STORE_EN
         RMW_RD: state_d = WRITE;
`endif
         WRITE:  state_d = RESP;
         RESP:   if (bus.rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ready_q   <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
`ifdef MEM_BYTE_STORE_EN
         byte_hi_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         // Registered ready keeps req_ready low for the first cycle out of reset.
         ready_q <= (state_d == IDLE);
         if (accept) begin
            addr_q  <= bus.req_addr[ADDR_W-1:0];
            wdata_q <= bus.req_wdata;
            err_q   <= out_of_range;
            rdata_q <= '0;
`ifdef MEM_BYTE_STORE_EN
            byte_hi_q <= bus.req_byte_hi;
`endif
         end
         if (state_q == READ)
            rdata_q <= bus.mem_rdata;
`ifdef MEM_BYTE_STORE_EN
         // wdata_q still holds the request word here; merge its low byte into the chosen lane.
         if (state_q == RMW_RD)
            wdata_q <= byte_hi_q ? {wdata_q[LANE_W-1:0], bus.mem_rdata[LANE_W-1:0]}
                                 : {bus.mem_rdata[DATA_W-1:LANE_W], wdata_q[LANE_W-1:0]};
`endif
         if ((state_q == RESP) && bus.rsp_ready) begin
            err_q   <= 1'b0;
            rdata_q <= '0;
         end
      end
   end

   assign bus.req_ready = ready_q;
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_we    = (state_q == WRITE);
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized traffic
// compared against a transaction-level memory model (honours MEM_BYTE_STORE_EN).
module tb_mem_access_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic [15:0] mem     [32];
   logic [15:0] ref_mem [32];

   mem_access_if bus ();

   mem_access_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

   always #5 clk = ~clk;

   assign bus.mem_rdata = mem[bus.mem_addr];
   always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;

`ifdef MEM_BYTE_STORE_EN
   localparam bit BYTE_EN = 1'b1;
`else
   localparam bit BYTE_EN = 1'b0;
`endif

   // Issue one request from a negedge context and wait for its response.
   task automatic do_txn(input logic wr, input logic by, input logic hi,
                         input logic [15:0] addr, input logic [15:0] wd,
                         output logic [15:0] rd, output logic er, output int lat,
                         output int we_cnt, output logic [4:0] we_addr);
      int guard = 0;
      bus.req_valid = 1'b1; bus.req_write = wr; bus.req_byte = by;
      bus.req_byte_hi = hi; bus.req_addr = addr; bus.req_wdata = wd;
      rd = '0; er = 1'b0; lat = -1; we_cnt = 0; we_addr = '0;
      while (!bus.req_ready && guard < 50) begin @(negedge clk); guard++; end
      if (!bus.req_ready) begin
         checks++; errors++;
         $display("FAIL accept_timeout addr=%h req_ready=%b required 1", addr, bus.req_ready);
         bus.req_valid = 1'b0;
         return;
      end
      @(posedge clk); #1 bus.req_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk); lat++;
         if (bus.mem_we) begin we_cnt++; we_addr = bus.mem_addr; end
      end while (!bus.rsp_valid && lat < 20);
      if (!bus.rsp_valid) begin
         checks++; errors++;
         $display("FAIL rsp_timeout addr=%h rsp_valid=%b required 1", addr, bus.rsp_valid);
      end
      rd = bus.rsp_rdata; er = bus.rsp_err;
      if (bus.rsp_ready) begin @(posedge clk); @(negedge clk); end
   endtask

   function automatic logic [15:0] exp_store(logic [15:0] old, logic by, logic hi, logic [15:0] wd);
      if (BYTE_EN && by) return hi ? {wd[7:0], old[7:0]} : {old[15:8], wd[7:0]};
      return wd;
   endfunction

   task automatic test_reset();
      bus.req_valid = 0; bus.req_write = 0; bus.req_byte = 0; bus.req_byte_hi = 0;
      bus.req_addr = 0; bus.req_wdata = 0; bus.rsp_ready = 1;
      #12;
      checks++;
      if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.mem_we} !== 4'b0 ||
          bus.rsp_rdata !== 16'h0 || bus.mem_addr !== 5'h0 || bus.mem_wdata !== 16'h0) begin
         errors++;
         $display("FAIL reset_outputs rdy=%b vld=%b err=%b we=%b rd=%h ma=%h wd=%h required all 0",
                  bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.mem_we, bus.rsp_rdata,
                  bus.mem_addr, bus.mem_wdata);
      end
      @(negedge clk); rst_n = 1'b1; #1;
      checks++;
      if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge got %b required 0", bus.req_ready); end
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_edge got %b required 1", bus.req_ready); end
      $display("reset: outputs cleared, req_ready rises after first edge");
   endtask

   task automatic test_store_load();
      logic [15:0] rd; logic er; int lat, wc; logic [4:0] wa;
      do_txn(1'b1, 1'b0, 1'b0, 16'h0005, 16'hBEEF, rd, er, lat, wc, wa);
      ref_mem[5] = 16'hBEEF;
      checks++;
      if (lat !== 2 || wc !== 1 || wa !== 5'd5 || er !== 1'b0 || rd !== 16'h0) begin
         errors++;
         $display("FAIL store_5 lat=%0d we=%0d waddr=%0d err=%b rd=%h required 2 1 5 0 0000", lat, wc, wa, er, rd);
      end
      $display("store addr=0005 data=BEEF lat=%0d we_cycles=%0d", lat, wc);
      checks++;
      if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
         errors++; $display("FAIL idle_after_store rdy=%b vld=%b required 1 0", bus.req_ready, bus.rsp_valid);
      end
      do_txn(1'b0, 1'b0, 1'b0, 16'h0005, 16'h0, rd, er, lat, wc, wa);
      checks++;
      if (lat !== 2 || wc !== 0 || er !== 1'b0 || rd !== ref_mem[5]) begin
         errors++;
         $display("FAIL load_5 lat=%0d we=%0d err=%b rd=%h required 2 0 0 %h", lat, wc, er, rd, ref_mem[5]);
      end
      $display("load  addr=0005 rdata=%h lat=%0d", rd, lat);
   endtask

   task automatic test_error();
      logic [15:0] rd; logic er; int lat, wc; logic [4:0] wa;
      do_txn(1'b0, 1'b0, 1'b0, 16'h0020, 16'h0, rd, er, lat, wc, wa);
      checks++;
      if (lat !== 1 || wc !== 0 || er !== 1'b1 || rd !== 16'h0) begin
         errors++; $display("FAIL load_oor lat=%0d we=%0d err=%b rd=%h required 1 0 1 0000", lat, wc, er, rd);
      end
      $display("load  addr=0020 err=%b lat=%0d", er, lat);
      do_txn(1'b1, 1'b0, 1'b0, 16'h0040, 16'h5A5A, rd, er, lat, wc, wa);
      checks++;
      if (lat !== 1 || wc !== 0 || er !== 1'b1 || rd !== 16'h0) begin
         errors++; $display("FAIL store_oor lat=%0d we=%0d err=%b rd=%h required 1 0 1 0000", lat, wc, er, rd);
      end
      $display("store addr=0040 err=%b we_cycles=%0d", er, wc);
   endtask

   task automatic test_backpressure();
      logic [15:0] rd; logic er; int lat, wc; logic [4:0] wa;
      bus.rsp_ready = 1'b0;
      do_txn(1'b0, 1'b0, 1'b0, 16'h0005, 16'h0, rd, er, lat, wc, wa);
      bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 16'h0003;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== ref_mem[5] || bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_rsp cyc=%0d vld=%b rd=%h rdy=%b required 1 %h 0", i, bus.rsp_valid,
                     bus.rsp_rdata, bus.req_ready, ref_mem[5]);
         end
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
         errors++; $display("FAIL release_rsp vld=%b rdy=%b required 0 1", bus.rsp_valid, bus.req_ready);
      end
      do_txn(1'b0, 1'b0, 1'b0, 16'h0003, 16'h0, rd, er, lat, wc, wa);
      checks++;
      if (lat !== 2 || er !== 1'b0 || rd !== ref_mem[3]) begin
         errors++; $display("FAIL pending_load lat=%0d err=%b rd=%h required 2 0 %h", lat, er, rd, ref_mem[3]);
      end
      $display("backpressure: held 5 cycles, pending load rdata=%h", rd);
   endtask

   task automatic test_byte_store();
      logic [15:0] rd; logic er; int lat, wc; logic [4:0] wa;
      do_txn(1'b1, 1'b0, 1'b0, 16'h0003, 16'h1234, rd, er, lat, wc, wa);
      ref_mem[3] = 16'h1234;
      do_txn(1'b1, 1'b1, 1'b1, 16'h0003, 16'h00AB, rd, er, lat, wc, wa);
      ref_mem[3] = exp_store(ref_mem[3], 1'b1, 1'b1, 16'h00AB);
      checks++;
      if (lat !== (BYTE_EN ? 3 : 2) || wc !== 1 || wa !== 5'd3 || er !== 1'b0) begin
         errors++;
         $display("FAIL byte_store lat=%0d we=%0d waddr=%0d err=%b required %0d 1 3 0", lat, wc, wa, er, BYTE_EN ? 3 : 2);
      end
      do_txn(1'b0, 1'b0, 1'b0, 16'h0003, 16'h0, rd, er, lat, wc, wa);
      checks++;
      if (rd !== (BYTE_EN ? 16'hAB34 : 16'h00AB) || er !== 1'b0) begin
         errors++; $display("FAIL byte_merge rd=%h required %h", rd, BYTE_EN ? 16'hAB34 : 16'h00AB);
      end
      $display("byte store hi 0xAB over 1234 -> %h", rd);
   endtask

   task automatic test_random();
      logic [15:0] rd; logic er; int lat, wc; logic [4:0] wa;
      for (int n = 0; n < 60; n++) begin
         logic wr, by, hi, oor; logic [15:0] addr, wd;
         int e_lat, e_wc; logic [15:0] e_rd;
         wr = 1'($urandom); by = 1'($urandom); hi = 1'($urandom);
         addr = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 31));
         wd = 16'($urandom);
         oor = (addr >= 32);
         e_lat = oor ? 1 : (!wr ? 2 : ((BYTE_EN && by) ? 3 : 2));
         e_wc  = (oor || !wr) ? 0 : 1;
         e_rd  = (oor || wr) ? 16'h0 : ref_mem[addr[4:0]];
         do_txn(wr, by, hi, addr, wd, rd, er, lat, wc, wa);
         if (!oor && wr) ref_mem[addr[4:0]] = exp_store(ref_mem[addr[4:0]], by, hi, wd);
         checks++;
         if (lat !== e_lat || wc !== e_wc || er !== oor || rd !== e_rd ||
             (e_wc == 1 && wa !== addr[4:0])) begin
            errors++;
            $display("FAIL rand_%0d wr=%b by=%b hi=%b addr=%h lat=%0d we=%0d err=%b rd=%h required %0d %0d %b %h",
                     n, wr, by, hi, addr, lat, wc, er, rd, e_lat, e_wc, oor, e_rd);
         end
         $display("rand %0d wr=%b by=%b hi=%b addr=%h wd=%h -> rd=%h err=%b lat=%0d", n, wr, by, hi, addr, wd, rd, er, lat);
      end
   endtask

   task automatic test_reset_mid_write();
      logic [15:0] rd; logic er; int lat, wc; logic [4:0] wa;
      int guard = 0;
      bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_byte = 1'b0;
      bus.req_addr = 16'h0009; bus.req_wdata = 16'hC0DE;
      while (!bus.req_ready && guard < 20) begin @(negedge clk); guard++; end
      @(posedge clk); #1 bus.req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL write_phase we=%b required 1", bus.mem_we); end
      rst_n = 1'b0; #1;
      checks++;
      if (bus.mem_we !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
         errors++; $display("FAIL async_abort we=%b vld=%b rdy=%b required 0 0 0", bus.mem_we, bus.rsp_valid, bus.req_ready);
      end
      @(negedge clk); rst_n = 1'b1; #1;
      checks++;
      if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL ready_post_reset got %b required 0", bus.req_ready); end
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL ready_first_edge got %b required 1", bus.req_ready); end
      do_txn(1'b0, 1'b0, 1'b0, 16'h0005, 16'h0, rd, er, lat, wc, wa);
      checks++;
      if (lat !== 2 || er !== 1'b0 || rd !== ref_mem[5] || wc !== 0) begin
         errors++; $display("FAIL load_after_reset lat=%0d err=%b rd=%h required 2 0 %h", lat, er, rd, ref_mem[5]);
      end
      do_txn(1'b1, 1'b0, 1'b0, 16'h0009, 16'h0F0F, rd, er, lat, wc, wa);
      ref_mem[9] = 16'h0F0F;
      $display("reset mid-write: aborted, load after reset rdata=%h", rd);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin mem[i] = 16'h0; ref_mem[i] = 16'h0; end
      test_reset();
      test_store_load();
      test_error();
      test_backpressure();
      test_byte_store();
      test_random();
      test_reset_mid_write();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
